gd_update_sequencer: RTL and testbench

- Sequences one Q8.8 capped-difference unit to run iterative gradient-descent updates on a DIM-element parameter vector: x[i] <= sat(x[i] - g[i]).
- Requests each pre-scaled gradient from the gradient unit over a valid/ready handshake and drives the shared subtractor one dimension at a time.
- Tracks iteration count, convergence and sticky saturation flags, and presents the final vector to the top level.

---
 rtl/gd_update_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_gd_update_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gd_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gd_update_sequencer
// Description : Drives one shared Q8.8 capped subtractor through iterative
//               gradient-descent updates x[i] <= sat(x[i] - g[i]).
// Revision    : 1.0 - initial release
// ============================================================================
module gd_update_sequencer #(
    parameter int DIM      = 4,
    parameter int W        = 16,
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DIM*W-1:0]       x_init,
    input  logic [W-1:0]           tol,
    output logic                   grad_req,
    output logic [$clog2(DIM)-1:0] grad_idx,
    input  logic                   grad_valid,
    input  logic [W-1:0]           grad_data,
    output logic [W-1:0]           sub_a,
    output logic [W-1:0]           sub_b,
    input  logic [W-1:0]           sub_result,
    input  logic                   sub_ovf,
    input  logic                   sub_unf,
    output logic [DIM*W-1:0]       x_out,
    output logic                   busy,
    output logic                   done,
    output logic                   converged,
    output logic                   sat_ovf,
    output logic                   sat_unf,
    output logic [ITER_W-1:0]      iter_count
);

    localparam int IDX_W = $clog2(DIM);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_WAIT   = 3'd1;
    localparam logic [2:0] c_UPDATE = 3'd2;
    localparam logic [2:0] c_CHECK  = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    localparam logic [IDX_W-1:0]  c_LAST = IDX_W'(DIM - 1);
    localparam logic [ITER_W-1:0] c_MAX  = ITER_W'(MAX_ITER);

    logic [2:0]        state_q, state_d;
    logic [W-1:0]      x_q [DIM];
    logic [W-1:0]      x_d [DIM];
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [W-1:0]      tol_q, tol_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              conv_q, conv_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              any_big_q, any_big_d;
    logic [W-1:0]      sub_a_q, sub_a_d;
    logic [W-1:0]      sub_b_q, sub_b_d;

    logic              w_abort;
    logic [W:0]        w_g_ext;
    logic [W:0]        w_g_mag;
    logic              w_big;
    logic [ITER_W-1:0] w_iter_inc;

    assign w_abort    = abort && (state_q != c_IDLE);
    assign w_iter_inc = iter_q + ITER_W'(1);

    // Magnitude is one bit wider so that |0x8000| is representable and exceeds any tol.
    assign w_g_ext = {grad_data[W-1], grad_data};
    assign w_g_mag = grad_data[W-1] ? ((~w_g_ext) + (W+1)'(1)) : w_g_ext;
    assign w_big   = w_g_mag > {1'b0, tol_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:   if (start) state_d = c_WAIT;
            c_WAIT:   if (grad_valid) state_d = c_UPDATE;
            c_UPDATE: state_d = (idx_q == c_LAST) ? c_CHECK : c_WAIT;
            c_CHECK: begin
                if (!any_big_q || (w_iter_inc == c_MAX)) state_d = c_DONE;
                else                                      state_d = c_WAIT;
            end
            c_DONE:   state_d = c_IDLE;
            default:  state_d = c_IDLE;
        endcase
        if (w_abort) state_d = c_IDLE;
    end

    always_comb begin
        grad_req = (state_q == c_WAIT);
        busy     = (state_q != c_IDLE);
        done     = (state_q == c_DONE);
    end

    always_comb begin
        x_d       = x_q;
        idx_d     = idx_q;
        tol_d     = tol_q;
        iter_d    = iter_q;
        conv_d    = conv_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        any_big_d = any_big_q;
        sub_a_d   = sub_a_q;
        sub_b_d   = sub_b_q;
        if (!w_abort) begin
            case (state_q)
                c_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < DIM; i++) x_d[i] = x_init[i*W +: W];
                        tol_d     = tol;
                        iter_d    = '0;
                        conv_d    = 1'b0;
                        ovf_d     = 1'b0;
                        unf_d     = 1'b0;
                        any_big_d = 1'b0;
                        idx_d     = '0;
                    end
                end
                c_WAIT: begin
                    // Operands are registered on the transfer so the subtractor sees them during UPDATE.
                    if (grad_valid) begin
                        sub_a_d   = x_q[idx_q];
                        sub_b_d   = grad_data;
                        any_big_d = any_big_q | w_big;
                    end
                end
                c_UPDATE: begin
                    x_d[idx_q] = sub_result;
                    ovf_d      = ovf_q | sub_ovf;
                    unf_d      = unf_q | sub_unf;
                    if (idx_q != c_LAST) idx_d = idx_q + IDX_W'(1);
                end
                c_CHECK: begin
                    iter_d = w_iter_inc;
                    if (!any_big_q) begin
                        conv_d = 1'b1;
                    end else if (w_iter_inc == c_MAX) begin
                        conv_d = 1'b0;
                    end else begin
                        any_big_d = 1'b0;
                        idx_d     = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++) x_q[i] <= '0;
            idx_q     <= '0;
            tol_q     <= '0;
            iter_q    <= '0;
            conv_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            any_big_q <= 1'b0;
            sub_a_q   <= '0;
            sub_b_q   <= '0;
        end else begin
            x_q       <= x_d;
            idx_q     <= idx_d;
            tol_q     <= tol_d;
            iter_q    <= iter_d;
            conv_q    <= conv_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            any_big_q <= any_big_d;
            sub_a_q   <= sub_a_d;
            sub_b_q   <= sub_b_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_xout
            assign x_out[gi*W +: W] = x_q[gi];
        end
    endgenerate

    assign grad_idx   = idx_q;
    assign sub_a      = sub_a_q;
    assign sub_b      = sub_b_q;
    assign converged  = conv_q;
    assign sat_ovf    = ovf_q;
    assign sat_unf    = unf_q;
    assign iter_count = iter_q;

endmodule
`default_nettype wire

// File: tb/tb_gd_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gd_update_sequencer
// Description : Directed bench with a capped-subtractor model, a gradient
//               responder and a scoreboard of expected run results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gd_update_sequencer;

    localparam int DIM      = 4;
    localparam int W        = 16;
    localparam int ITER_W   = 8;
    localparam int MAX_ITER = 3;
    localparam int IDX_W    = $clog2(DIM);

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic [DIM*W-1:0]   x_init;
    logic [W-1:0]       tol;
    logic               grad_req;
    logic [IDX_W-1:0]   grad_idx;
    logic               grad_valid;
    logic [W-1:0]       grad_data;
    logic [W-1:0]       sub_a;
    logic [W-1:0]       sub_b;
    logic [W-1:0]       sub_result;
    logic               sub_ovf;
    logic               sub_unf;
    logic [DIM*W-1:0]   x_out;
    logic               busy;
    logic               done;
    logic               converged;
    logic               sat_ovf;
    logic               sat_unf;
    logic [ITER_W-1:0]  iter_count;

    gd_update_sequencer #(
        .DIM      (DIM),
        .W        (W),
        .ITER_W   (ITER_W),
        .MAX_ITER (MAX_ITER)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .x_init     (x_init),
        .tol        (tol),
        .grad_req   (grad_req),
        .grad_idx   (grad_idx),
        .grad_valid (grad_valid),
        .grad_data  (grad_data),
        .sub_a      (sub_a),
        .sub_b      (sub_b),
        .sub_result (sub_result),
        .sub_ovf    (sub_ovf),
        .sub_unf    (sub_unf),
        .x_out      (x_out),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .sat_ovf    (sat_ovf),
        .sat_unf    (sat_unf),
        .iter_count (iter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural capped subtractor
    logic [W:0] w_diff;
    assign w_diff     = {sub_a[W-1], sub_a} - {sub_b[W-1], sub_b};
    assign sub_ovf    = (w_diff[W:W-1] == 2'b01);
    assign sub_unf    = (w_diff[W:W-1] == 2'b10);
    assign sub_result = sub_ovf ? {1'b0, {(W-1){1'b1}}} :
                        sub_unf ? {1'b1, {(W-1){1'b0}}} : w_diff[W-1:0];

    typedef struct {
        logic [DIM*W-1:0]  x;
        logic              conv;
        logic [ITER_W-1:0] iter;
        logic              ovf;
        logic              unf;
    } exp_t;

    exp_t        sb_q[$];
    logic [W-1:0] gvec [DIM];
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [DIM*W-1:0] xi, input logic [W-1:0] tl);
        exp_t e;
        int   xv [DIM];
        int   gi, mag, d, tln;
        bit   big, fin;
        e.conv = 1'b0; e.ovf = 1'b0; e.unf = 1'b0; e.iter = '0;
        tln = tl;
        fin = 1'b0;
        for (int i = 0; i < DIM; i++) xv[i] = $signed(xi[i*W +: W]);
        for (int it = 0; it < MAX_ITER; it++) begin
            if (!fin) begin
                big = 1'b0;
                for (int i = 0; i < DIM; i++) begin
                    gi  = $signed(gvec[i]);
                    mag = (gi < 0) ? -gi : gi;
                    if (mag > tln) big = 1'b1;
                    d = xv[i] - gi;
                    if (d > 32767)       begin d = 32767;  e.ovf = 1'b1; end
                    else if (d < -32768) begin d = -32768; e.unf = 1'b1; end
                    xv[i] = d;
                end
                e.iter = ITER_W'(it + 1);
                if (!big) begin
                    e.conv = 1'b1;
                    fin    = 1'b1;
                end
            end
        end
        for (int i = 0; i < DIM; i++) e.x[i*W +: W] = xv[i][W-1:0];
        return e;
    endfunction

    // Called at #1 after a clock edge; returns at #1 after the edge following done.
    task automatic run_case(input string tag, input logic [DIM*W-1:0] xi, input logic [W-1:0] tl,
                            input int nwait, input bit hold, input bit glitch, output int cyc);
        exp_t             e;
        int               cnt;
        bit               fin;
        logic [IDX_W-1:0] pidx;
        logic [DIM*W-1:0] px;
        sb_q.push_back(model(xi, tl));
        x_init     = xi;
        tol        = tl;
        start      = 1'b1;
        grad_valid = hold;
        grad_data  = gvec[0];
        cyc = 0; cnt = 0; fin = 1'b0;
        pidx = '0; px = '0;
        while (!fin) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (glitch && cyc == 3) begin start = 1'b1; x_init = ~xi; end
            if (glitch && cyc == 4) x_init = xi;
            if (done) begin
                fin = 1'b1;
                if (sb_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $error("FAIL %s_sb: observed empty queue expected entry", tag);
                end else begin
                    e = sb_q.pop_front();
                    chk({tag, "_x"},    x_out,      e.x);
                    chk({tag, "_conv"}, converged,  e.conv);
                    chk({tag, "_iter"}, iter_count, e.iter);
                    chk({tag, "_ovf"},  sat_ovf,    e.ovf);
                    chk({tag, "_unf"},  sat_unf,    e.unf);
                end
            end else if (cyc > 3000) begin
                fin = 1'b1;
                n_cmp++; n_fail++;
                $error("FAIL %s_timeout: observed no done expected done within 3000 cycles", tag);
            end else begin
                grad_data = gvec[grad_idx];
                if (grad_req) begin
                    if (cnt == 0) begin
                        pidx = grad_idx;
                        px   = x_out;
                    end else begin
                        chk({tag, "_bp_idx"}, grad_idx, pidx);
                        chk({tag, "_bp_x"},   x_out,    px);
                    end
                    grad_valid = hold || (cnt >= nwait);
                    cnt++;
                end else begin
                    grad_valid = hold;
                    cnt = 0;
                end
            end
        end
        grad_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_idle"},       busy, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x"},    x_out,      '0);
        chk({tag, "_busy"}, busy,       1'b0);
        chk({tag, "_done"}, done,       1'b0);
        chk({tag, "_conv"}, converged,  1'b0);
        chk({tag, "_ovf"},  sat_ovf,    1'b0);
        chk({tag, "_unf"},  sat_unf,    1'b0);
        chk({tag, "_iter"}, iter_count, '0);
        chk({tag, "_req"},  grad_req,   1'b0);
        chk({tag, "_suba"}, sub_a,      '0);
    endtask

    initial begin
        int               cyc;
        int               n;
        bit               hit;
        logic [DIM*W-1:0] xi;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        grad_valid = 1'b0; grad_data = '0; x_init = '0; tol = '0;
        for (int i = 0; i < DIM; i++) gvec[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero gradient: converges after one iteration, done 10 cycles after start
        xi = {4{16'h0100}};
        run_case("zero", xi, 16'h0000, 0, 1'b1, 1'b0, cyc);
        chk("zero_latency", cyc, 10);
        chk("zero_xconst", x_out, xi);

        // Positive and negative capping
        gvec[0] = 16'hFF00; gvec[1] = 16'h0200; gvec[2] = 16'h0000; gvec[3] = 16'h0000;
        run_case("cap", {16'h0000, 16'h0000, 16'h8100, 16'h7F00}, 16'h0000, 0, 1'b0, 1'b0, cyc);
        chk("cap_x0", x_out[15:0],  16'h7FFF);
        chk("cap_x1", x_out[31:16], 16'h8000);

        // Iteration limit
        for (int i = 0; i < DIM; i++) gvec[i] = 16'h0010;
        run_case("limit", {4{16'h0200}}, 16'h0008, 0, 1'b0, 1'b0, cyc);
        chk("limit_xconst", x_out, {4{16'h01D0}});
        repeat (3) @(posedge clk);
        #1;
        chk("limit_hold_iter", iter_count, 8'd3);
        chk("limit_hold_x",    x_out,      {4{16'h01D0}});

        // Backpressure: same run with the gradient withheld 5 cycles per request
        run_case("bp", {4{16'h0200}}, 16'h0008, 5, 1'b0, 1'b0, cyc);
        chk("bp_xconst", x_out, {4{16'h01D0}});

        // |g| equal to tol on every dimension counts as small
        gvec[0] = 16'h0030; gvec[1] = 16'hFFD0; gvec[2] = 16'h0030; gvec[3] = 16'hFFD0;
        run_case("tol_eq", {4{16'h0400}}, 16'h0030, 0, 1'b0, 1'b0, cyc);
        chk("tol_eq_x", x_out, {16'h0430, 16'h03D0, 16'h0430, 16'h03D0});

        // Most negative gradient always exceeds tol
        gvec[0] = 16'h8000; gvec[1] = 16'h0000; gvec[2] = 16'h0000; gvec[3] = 16'h0000;
        run_case("gmin", '0, 16'h7FFF, 0, 1'b0, 1'b0, cyc);
        chk("gmin_conv", converged, 1'b0);

        // Abort in the third WAIT
        for (int i = 0; i < DIM; i++) gvec[i] = 16'h0010;
        x_init = {4{16'h0200}}; tol = '0; start = 1'b1; grad_valid = 1'b0;
        n = 0; hit = 1'b0;
        while (!hit && n < 50) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (grad_req && grad_idx == 2) begin
                hit = 1'b1;
            end else begin
                grad_valid = grad_req;
                grad_data  = gvec[grad_idx];
            end
        end
        chk("abort_reach", hit, 1'b1);
        grad_valid = 1'b0;
        abort      = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy,     1'b0);
        chk("abort_req",  grad_req, 1'b0);
        chk("abort_done", done,     1'b0);
        chk("abort_x",    x_out,    {16'h0200, 16'h0200, 16'h01F0, 16'h01F0});
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort_nodone", done, 1'b0);
        end

        // Asynchronous reset in the middle of a capping run
        gvec[0] = 16'hFF00; gvec[1] = 16'h0200; gvec[2] = 16'h0000; gvec[3] = 16'h0000;
        x_init = {16'h0000, 16'h0000, 16'h8100, 16'h7F00}; start = 1'b1; grad_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            start     = 1'b0;
            grad_data = gvec[grad_idx];
        end
        chk("prerst_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        grad_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Restart after reset, with start pulses while busy that must be ignored
        for (int i = 0; i < DIM; i++) gvec[i] = '0;
        run_case("restart", {4{16'h0100}}, 16'h0000, 0, 1'b1, 1'b1, cyc);
        chk("restart_latency", cyc, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
